// File: rtl/sequenced_datapath.sv
// Sequenced single-bus datapath: a small register file, Y/Z/MDR/HI/LO
// registers and a five-state controller that runs one operation at a time
// through fetch-A (T1), fetch-B/execute (T2), writeback (T3) and DONE.
module sequenced_datapath #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  input  logic [AW-1:0]    Rd,
  input  logic [WIDTH-1:0] Mdatain,
  output logic             Busy,
  output logic             Done,
  input  logic [AW-1:0]    DbgAddr,
  output logic [WIDTH-1:0] DbgData,
  output logic [WIDTH-1:0] HIout,
  output logic [WIDTH-1:0] LOout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_MUL  = 3'b100,
    OP_LOAD = 3'b101,
    OP_MOVE = 3'b110,
    OP_NOP  = 3'b111
  } op_t;

  // Controller and latched command
  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic [AW-1:0]     rb_q, rb_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Datapath registers
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   r_q [NREGS];
  logic [WIDTH-1:0]   r_d [NREGS];

  // Combinational helpers
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] bus;
  logic             rd_valid;

  // Register-file read ports; out-of-range indices read as zero
  always_comb begin
    src_a    = (int'(ra_q) < NREGS) ? r_q[ra_q] : '0;
    src_b    = (int'(rb_q) < NREGS) ? r_q[rb_q] : '0;
    rd_valid = (int'(rd_q) < NREGS);
    DbgData  = (int'(DbgAddr) < NREGS) ? r_q[DbgAddr] : '0;
  end

  // Single bus: one driver per state, idle-zero outside T1/T2
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    bus = '0;
    case (state_q)
      S_T1:    bus = (op_q == OP_LOAD) ? Mdatain : src_a;
      S_T2:    bus = src_b;
      default: bus = '0;
    endcase
  end

  // Next-state, execute and writeback logic for the whole sequence
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    y_d     = y_q;
    mdr_d   = mdr_q;
    z_d     = z_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    r_d     = r_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = op_t'(Op);
          ra_d    = Ra;
          rb_d    = Rb;
          rd_d    = Rd;
          state_d = S_T1;
        end
      end

      S_T1: begin
        if (op_q == OP_LOAD) begin
          mdr_d = bus;
        end else if (op_q != OP_NOP) begin
          y_d = bus;
        end
        state_d = (op_q == OP_LOAD || op_q == OP_NOP) ? S_T3 : S_T2;
      end

      S_T2: begin
        case (op_q)
          OP_ADD:  z_d = {{WIDTH{1'b0}}, y_q + bus};
          OP_SUB:  z_d = {{WIDTH{1'b0}}, y_q - bus};
          OP_AND:  z_d = {{WIDTH{1'b0}}, y_q & bus};
          OP_OR:   z_d = {{WIDTH{1'b0}}, y_q | bus};
          OP_MUL:  z_d = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus};
          OP_MOVE: z_d = {{WIDTH{1'b0}}, y_q};
          default: z_d = z_q;
        endcase
        state_d = S_T3;
      end

      S_T3: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOVE: begin
            if (rd_valid) r_d[rd_q] = z_q[WIDTH-1:0];
          end
          OP_MUL: begin
            hi_d = z_q[2*WIDTH-1:WIDTH];
            lo_d = z_q[WIDTH-1:0];
          end
          OP_LOAD: begin
            if (rd_valid) r_d[rd_q] = mdr_q;
          end
          default: ;
        endcase
        state_d = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so they follow the state being entered
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State registers with asynchronous clear
  always_ff @(posedge Clock or posedge Clear) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (Clear) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      mdr_q   <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      // NOTE: the register file is cleared on reset, so it is built from
      // flops rather than a RAM macro, which has no reset.
      for (int i = 0; i < NREGS; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      mdr_q   <= mdr_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      for (int i = 0; i < NREGS; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign HIout = hi_q;
  assign LOout = lo_q;

endmodule

// File: tb/tb_sequenced_datapath.sv
// Directed bench for sequenced_datapath: a 32-bit/16-register instance and
// an 8-bit/4-register instance sharing command inputs, each with its own Start.
module tb_sequenced_datapath;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_MOVE = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic        clk;
  logic        clear;
  logic        start_a, start_b;
  logic [2:0]  op;
  logic [3:0]  ra, rb, rd, dbg_addr;
  logic [31:0] mdatain;

  logic        busy_a, done_a;
  logic [31:0] dbg_a, hi_a, lo_a;
  logic        busy_b, done_b;
  logic [7:0]  dbg_b, hi_b, lo_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_a [16];

  sequenced_datapath #(.WIDTH(32), .NREGS(16)) u_a (
    .Clock(clk), .Clear(clear), .Start(start_a), .Op(op),
    .Ra(ra), .Rb(rb), .Rd(rd), .Mdatain(mdatain),
    .Busy(busy_a), .Done(done_a), .DbgAddr(dbg_addr),
    .DbgData(dbg_a), .HIout(hi_a), .LOout(lo_a)
  );

  sequenced_datapath #(.WIDTH(8), .NREGS(4)) u_b (
    .Clock(clk), .Clear(clear), .Start(start_b), .Op(op),
    .Ra(ra[1:0]), .Rb(rb[1:0]), .Rd(rd[1:0]), .Mdatain(mdatain[7:0]),
    .Busy(busy_b), .Done(done_b), .DbgAddr(dbg_addr[1:0]),
    .DbgData(dbg_b), .HIout(hi_b), .LOout(lo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read a register through the debug port of instance a (sel=0) or b (sel=1)
  task automatic peek(input bit sel, input int idx, output logic [31:0] v);
    dbg_addr = idx[3:0];
    #1;
    v = sel ? {24'h0, dbg_b} : dbg_a;
  endtask

  // Issue one operation and measure the cycle in which Done is seen
  task automatic do_op(input bit sel, input logic [2:0] o, input int a, input int b,
                       input int d, input logic [31:0] md, input int exp_lat,
                       input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    op      = o;
    ra      = a[3:0];
    rb      = b[3:0];
    rd      = d[3:0];
    mdatain = md;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [31:0] v;
    int          saw_done;

    clear    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    op       = OP_NOP;
    ra       = '0;
    rb       = '0;
    rd       = '0;
    mdatain  = '0;
    dbg_addr = '0;
    for (int i = 0; i < 16; i++) model_a[i] = '0;

    // Reset state
    #12;
    check("rst_busy_a", 64'(busy_a), 64'(0));
    check("rst_done_a", 64'(done_a), 64'(0));
    check("rst_hi_a", 64'(hi_a), 64'(0));
    check("rst_lo_a", 64'(lo_a), 64'(0));
    check("rst_busy_b", 64'(busy_b), 64'(0));
    check("rst_hilo_b", 64'({hi_b, lo_b}), 64'(0));
    peek(0, 5, v);
    check("rst_r5_a", 64'(v), 64'(0));
    @(negedge clk);
    clear = 1'b0;

    // LOAD into R3: Done in cycle 3, only R3 written
    do_op(0, OP_LOAD, 0, 0, 3, 32'h0000_0025, 3, "load_r3");
    model_a[3] = 32'h0000_0025;
    for (int i = 0; i < 16; i++) begin
      peek(0, i, v);
      check($sformatf("load_r%0d", i), 64'(v), 64'(model_a[i]));
    end

    // ADD/SUB wrap-around
    do_op(0, OP_LOAD, 0, 0, 1, 32'hFFFF_FFFF, 3, "load_r1");
    model_a[1] = 32'hFFFF_FFFF;
    do_op(0, OP_LOAD, 0, 0, 2, 32'h0000_0002, 3, "load_r2");
    model_a[2] = 32'h0000_0002;
    do_op(0, OP_ADD, 1, 2, 4, 32'h0, 4, "add");
    model_a[4] = 32'h0000_0001;
    peek(0, 4, v);
    check("add_r4", 64'(v), 64'(32'h0000_0001));
    do_op(0, OP_SUB, 2, 1, 5, 32'h0, 4, "sub");
    model_a[5] = 32'h0000_0003;
    peek(0, 5, v);
    check("sub_r5", 64'(v), 64'(32'h0000_0003));

    // Full unsigned product into HI/LO, register file untouched
    do_op(0, OP_LOAD, 0, 0, 2, 32'hFFFF_FFFF, 3, "load_r2b");
    model_a[2] = 32'hFFFF_FFFF;
    do_op(0, OP_MUL, 1, 2, 9, 32'h0, 4, "mul");
    check("mul_hi", 64'(hi_a), 64'(32'hFFFF_FFFE));
    check("mul_lo", 64'(lo_a), 64'(32'h0000_0001));
    for (int i = 0; i < 16; i++) begin
      peek(0, i, v);
      check($sformatf("mul_keep_r%0d", i), 64'(v), 64'(model_a[i]));
    end

    // Aliased ADD R6 = R6 + R6 with a LOAD Start pulse during T2
    do_op(0, OP_LOAD, 0, 0, 6, 32'h0000_0010, 3, "load_r6");
    @(negedge clk);
    op = OP_ADD; ra = 4'd6; rb = 4'd6; rd = 4'd6; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(negedge clk);                       // cycle 1, T1
    check("alias_busy_t1", 64'(busy_a), 64'(1));
    @(negedge clk);                       // cycle 2, T2: Start sampled at next edge
    op = OP_LOAD; rd = 4'd2; mdatain = 32'hDEAD_BEEF; start_a = 1'b1;
    @(negedge clk);                       // cycle 3, T3
    start_a = 1'b0;
    check("alias_done_c3", 64'(done_a), 64'(0));
    @(negedge clk);                       // cycle 4, DONE
    check("alias_done_c4", 64'(done_a), 64'(1));
    peek(0, 6, v);
    check("alias_r6", 64'(v), 64'(32'h0000_0020));
    peek(0, 2, v);
    check("alias_r2_kept", 64'(v), 64'(32'hFFFF_FFFF));
    @(negedge clk);
    check("alias_busy_after", 64'(busy_a), 64'(0));
    check("alias_done_after", 64'(done_a), 64'(0));
    @(negedge clk);
    check("alias_no_second_op", 64'(busy_a), 64'(0));

    // Clear during T2 of a MOVE aborts it
    do_op(0, OP_LOAD, 0, 0, 1, 32'h0000_0055, 3, "load_r1_55");
    @(negedge clk);
    op = OP_MOVE; ra = 4'd1; rb = 4'd0; rd = 4'd7; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(negedge clk);                       // T1
    @(negedge clk);                       // T2
    check("abort_busy_pre", 64'(busy_a), 64'(1));
    clear = 1'b1;
    #1;
    check("abort_busy_now", 64'(busy_a), 64'(0));
    check("abort_done_now", 64'(done_a), 64'(0));
    @(negedge clk);
    clear = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_a) saw_done = 1;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));
    peek(0, 7, v);
    check("abort_r7", 64'(v), 64'(0));
    peek(0, 1, v);
    check("abort_r1_cleared", 64'(v), 64'(0));
    do_op(0, OP_MOVE, 1, 0, 7, 32'h0, 4, "move_after");
    peek(0, 7, v);
    check("move_after_r7", 64'(v), 64'(0));

    // Narrow instance: 8-bit ADD wrap and NOP
    do_op(1, OP_LOAD, 0, 0, 1, 32'h0000_00F0, 3, "b_load_r1");
    do_op(1, OP_LOAD, 0, 0, 2, 32'h0000_0020, 3, "b_load_r2");
    do_op(1, OP_ADD, 1, 2, 3, 32'h0, 4, "b_add");
    peek(1, 3, v);
    check("b_add_r3", 64'(v), 64'(32'h10));
    do_op(1, OP_NOP, 1, 2, 3, 32'h0000_00AA, 3, "b_nop");
    peek(1, 3, v);
    check("b_nop_r3", 64'(v), 64'(32'h10));
    peek(1, 1, v);
    check("b_nop_r1", 64'(v), 64'(32'hF0));
    peek(1, 0, v);
    check("b_nop_r0", 64'(v), 64'(0));
    check("b_nop_hilo", 64'({hi_b, lo_b}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
